perceptron_layer_seq: RTL and testbench

//  Parametrised, time-multiplexed perceptron layer: N_NEURON neurons x N_IN inputs sharing one signed MAC.

---
 rtl/perceptron_layer_seq_pkg.sv | 40 ++++
 rtl/perceptron_layer_seq_if.sv | 24 ++
 rtl/perceptron_layer_seq_mac.sv | 35 +++
 rtl/perceptron_layer_seq.sv | 168 ++++++++++++++++
 tb/tb_perceptron_layer_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_layer_seq_pkg.sv
// Shared types and helpers for the time-multiplexed perceptron layer.
// Build option: define PERCEPTRON_RELU_EN for saturating-ReLU activation instead of binary step.
package perceptron_layer_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadParam,
        StLoadIn,
        StCompute,
        StDone
    } state_e;

    // Index width that stays >= 1 bit even for single-entry arrays.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned min_acc_w(input int unsigned data_w, input int unsigned n_in);
        return 2 * data_w + $clog2(n_in + 1);
    endfunction

    // Operates on sign-extended 64-bit values; the caller truncates to DATA_W.
    function automatic logic signed [63:0] activate(input logic signed [63:0] acc,
                                                    input logic signed [63:0] thr,
                                                    input int unsigned        data_w);
        if (acc <= thr) begin
            return '0;
        end
`ifdef PERCEPTRON_RELU_EN
        begin
            logic signed [63:0] sat;
            sat = (64'sd1 <<< (data_w - 1)) - 64'sd1;
            return (acc > sat) ? sat : acc;
        end
`else
        return (data_w > 0) ? 64'sd1 : 64'sd0;
`endif
    endfunction

endpackage

// File: rtl/perceptron_layer_seq_if.sv
// Streaming input / result handshake bundle of the perceptron layer.
interface perceptron_layer_seq_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N_NEURON = 4
);
    logic                         cfg_load;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            in_data;
    logic [DATA_W-1:0]            threshold;
    logic                         out_valid;
    logic                         out_ready;
    logic [N_NEURON*DATA_W-1:0]   out_data;

    modport master (
        output cfg_load, in_valid, in_data, threshold, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_load, in_valid, in_data, threshold, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/perceptron_layer_seq_mac.sv
// Shared signed multiply-accumulate; init loads the sign-extended bias plus the first product.
module perceptron_layer_seq_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     init_i,
    input  logic signed [DATA_W-1:0] bias_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_d, acc_q;

    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (en_i) begin
            acc_d = (init_i ? ACC_W'(bias_i) : acc_q) + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/perceptron_layer_seq.sv
// Time-multiplexed perceptron layer: byte-streamed parameters/inputs, one shared MAC, flat result.
// Build option: PERCEPTRON_RELU_EN selects saturating ReLU activation (see package).
module perceptron_layer_seq
    import perceptron_layer_seq_pkg::*;
#(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned N_NEURON = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    perceptron_layer_seq_if.slave   bus,
    output logic                    param_loaded,
    output logic                    busy
);
    localparam int unsigned P  = N_NEURON * (N_IN + 1);
    localparam int unsigned PW = idx_w(P);
    localparam int unsigned IW = idx_w(N_IN);
    localparam int unsigned NW = idx_w(N_NEURON);
    localparam int unsigned CW = idx_w(N_IN + 1);

    if (ACC_W < min_acc_w(DATA_W, N_IN)) begin : g_acc_w_check
        $error("ACC_W too narrow for DATA_W/N_IN");
    end

    state_e                    state_q;
    logic signed [DATA_W-1:0]  param_q [P];
    logic signed [DATA_W-1:0]  x_q [N_IN];
    logic signed [DATA_W-1:0]  thr_q;
    logic        [DATA_W-1:0]  out_q [N_NEURON];
    logic        [PW-1:0]      pidx_q, nbase_q;
    logic        [IW-1:0]      iidx_q;
    logic        [NW-1:0]      nidx_q;
    logic        [CW-1:0]      cidx_q;
    logic                      out_valid_q, param_loaded_q;

    logic                      in_ready, beat, mac_en, mac_init;
    logic        [PW-1:0]      w_addr, b_addr;
    logic        [IW-1:0]      x_idx;
    logic signed [ACC_W-1:0]   mac_acc;
    logic        [DATA_W-1:0]  act;

    always_comb begin
        unique case (state_q)
            StIdle:                 in_ready = bus.cfg_load | param_loaded_q;
            StLoadParam, StLoadIn:  in_ready = 1'b1;
            default:                in_ready = 1'b0;
        endcase
        beat     = bus.in_valid & in_ready;
        mac_en   = (state_q == StCompute) && (cidx_q < CW'(N_IN));
        mac_init = (cidx_q == '0);
        w_addr   = nbase_q + PW'(cidx_q);
        b_addr   = nbase_q + PW'(N_IN);
        x_idx    = cidx_q[IW-1:0];
        act      = DATA_W'(activate(64'(mac_acc), 64'(thr_q), DATA_W));
    end

    perceptron_layer_seq_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i  (clk),
        .rst_i  (reset),
        .en_i   (mac_en),
        .init_i (mac_init),
        .bias_i (param_q[b_addr]),
        .a_i    (param_q[w_addr]),
        .b_i    (x_q[x_idx]),
        .acc_o  (mac_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            for (int p = 0; p < int'(P); p++) param_q[p] <= '0;
            for (int i = 0; i < int'(N_IN); i++) x_q[i] <= '0;
            for (int n = 0; n < int'(N_NEURON); n++) out_q[n] <= '0;
            thr_q          <= '0;
            pidx_q         <= '0;
            nbase_q        <= '0;
            iidx_q         <= '0;
            nidx_q         <= '0;
            cidx_q         <= '0;
            out_valid_q    <= 1'b0;
            param_loaded_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (beat && bus.cfg_load) begin
                        param_q[0]     <= bus.in_data;
                        pidx_q         <= PW'(1);
                        param_loaded_q <= 1'b0;
                        state_q        <= StLoadParam;
                    end else if (beat) begin
                        x_q[0] <= bus.in_data;
                        iidx_q <= IW'(1);
                        if (N_IN == 1) begin
                            thr_q   <= bus.threshold;
                            nbase_q <= '0;
                            nidx_q  <= '0;
                            cidx_q  <= '0;
                            state_q <= StCompute;
                        end else begin
                            state_q <= StLoadIn;
                        end
                    end
                end
                StLoadParam: begin
                    if (beat) begin
                        param_q[pidx_q] <= bus.in_data;
                        pidx_q          <= pidx_q + PW'(1);
                        if (pidx_q == PW'(P - 1)) begin
                            param_loaded_q <= 1'b1;
                            state_q        <= StIdle;
                        end
                    end
                end
                StLoadIn: begin
                    if (beat) begin
                        x_q[iidx_q] <= bus.in_data;
                        iidx_q      <= iidx_q + IW'(1);
                        if (iidx_q == IW'(N_IN - 1)) begin
                            thr_q   <= bus.threshold;
                            nbase_q <= '0;
                            nidx_q  <= '0;
                            cidx_q  <= '0;
                            state_q <= StCompute;
                        end
                    end
                end
                StCompute: begin
                    // Cycle N_IN of each neuron is the activation slot; the MAC is idle then.
                    if (cidx_q == CW'(N_IN)) begin
                        out_q[nidx_q] <= act;
                        cidx_q        <= '0;
                        nbase_q       <= nbase_q + PW'(N_IN + 1);
                        if (nidx_q == NW'(N_NEURON - 1)) begin
                            state_q <= StDone;
                        end else begin
                            nidx_q <= nidx_q + NW'(1);
                        end
                    end else begin
                        cidx_q <= cidx_q + CW'(1);
                    end
                end
                StDone: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign param_loaded  = param_loaded_q;
    assign busy          = (state_q != StIdle);

    for (genvar n = 0; n < int'(N_NEURON); n++) begin : g_out
        assign bus.out_data[n*DATA_W +: DATA_W] = out_q[n];
    end
endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Self-checking bench for perceptron_layer_seq: directed scenarios plus randomized inferences.
module tb_perceptron_layer_seq;
    localparam int N_IN     = 4;
    localparam int N_NEURON = 4;
    localparam int DATA_W   = 8;
    localparam int ACC_W    = 20;
    localparam int P        = N_NEURON * (N_IN + 1);

    logic clk = 1'b0;
    logic reset;
    logic param_loaded, busy;

    perceptron_layer_seq_if #(.DATA_W(DATA_W), .N_NEURON(N_NEURON)) bus ();

    perceptron_layer_seq #(
        .N_IN     (N_IN),
        .N_NEURON (N_NEURON),
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .param_loaded (param_loaded),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int w [N_NEURON][N_IN];
    int b [N_NEURON];
    int x [N_IN];
    logic [31:0] exp_q [$];
    bit rnd_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer dot product, then the activation rule.
    function automatic logic [31:0] model(input int thr);
        logic [31:0] r = '0;
        for (int n = 0; n < N_NEURON; n++) begin
            int acc = b[n];
            int v;
            for (int i = 0; i < N_IN; i++) acc += w[n][i] * x[i];
`ifdef PERCEPTRON_RELU_EN
            v = (acc <= thr) ? 0 : ((acc > 127) ? 127 : acc);
`else
            v = (acc > thr) ? 1 : 0;
`endif
            r[n*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic int rnd_byte();
        logic [7:0] r = 8'($urandom);
        return int'($signed(r));
    endfunction

    // Every valid cycle must show the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_data", bus.out_data, exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic cfg, input int data);
        int t = 0;
        bus.cfg_load = cfg;
        bus.in_valid = 1'b1;
        bus.in_data  = data[7:0];
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("beat_accepted", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_load = 1'b0;
    endtask

    task automatic load_params(input bit rand_cfg);
        for (int p = 0; p < P; p++) begin
            int n = p / (N_IN + 1);
            int i = p % (N_IN + 1);
            logic c = (p == 0) ? 1'b1 : (rand_cfg ? 1'($urandom) : 1'b0);
            send_beat(c, (i < N_IN) ? w[n][i] : b[n]);
        end
    endtask

    task automatic send_inputs(input int thr);
        bus.threshold = 8'(thr);
        exp_q.push_back(model(thr));
        for (int i = 0; i < N_IN; i++) begin
            send_beat((i == 0) ? 1'b0 : 1'($urandom), x[i]);
        end
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.out_ready = 1'($urandom);
            t++;
        end
        check("done_in_time", busy, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] lit;
        reset         = 1'b1;
        bus.cfg_load  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.threshold = '0;
        bus.out_ready = 1'b0;

        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_param_loaded", param_loaded, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready_no_cfg", bus.in_ready, 0);
        @(posedge clk);
        #1;

        // 2: weights all 1, biases 0,-10,5,-1
        for (int n = 0; n < N_NEURON; n++) for (int i = 0; i < N_IN; i++) w[n][i] = 1;
        b[0] = 0; b[1] = -10; b[2] = 5; b[3] = -1;
        load_params(1'b0);
        check("load_param_loaded", param_loaded, 1);
        check("load_busy", busy, 0);

        // 3: inputs 1..4, threshold 0, latency 21 edges
        for (int i = 0; i < N_IN; i++) x[i] = i + 1;
        send_inputs(0);
        k = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                k = e;
                break;
            end
        end
        check("latency_edges", k, 21);
`ifdef PERCEPTRON_RELU_EN
        lit = 32'h090F000A;
`else
        lit = 32'h01010001;
`endif
        check("lit_basic", bus.out_data, lit);

        // 4: stall in DONE, then handshake
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_out_data", bus.out_data, lit);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("hs_busy", busy, 0);
        check("hs_out_valid", bus.out_valid, 0);
        check("hs_out_data_kept", bus.out_data, lit);

        // 5: extreme values
        for (int n = 0; n < N_NEURON; n++) begin
            b[n] = 127;
            for (int i = 0; i < N_IN; i++) w[n][i] = 127;
        end
        load_params(1'b1);
        for (int i = 0; i < N_IN; i++) x[i] = 127;
        send_inputs(0);
        bus.out_ready = 1'b1;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
`ifdef PERCEPTRON_RELU_EN
        check("lit_max", bus.out_data, 32'h7F7F7F7F);
`else
        check("lit_max", bus.out_data, 32'h01010101);
`endif
        wait_done(20);
        for (int i = 0; i < N_IN; i++) x[i] = -128;
        send_inputs(0);
        bus.out_ready = 1'b1;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("lit_min", bus.out_data, 32'h00000000);
        wait_done(20);

        // 6: reset mid-compute
        for (int i = 0; i < N_IN; i++) x[i] = rnd_byte();
        send_inputs(rnd_byte());
        repeat (7) @(posedge clk);
        #1;
        check("mid_compute_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("abort_busy", busy, 0);
        check("abort_param_loaded", param_loaded, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out_data", bus.out_data, 0);
        reset = 1'b0;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("abort_refuse_input", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("abort_still_idle", busy, 0);
        bus.in_valid = 1'b0;

        // Randomized parameter sets and inferences with random back-pressure
        rnd_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            for (int n = 0; n < N_NEURON; n++) begin
                b[n] = rnd_byte();
                for (int i = 0; i < N_IN; i++) w[n][i] = (s == 0) ? (rnd_byte() % 4) : rnd_byte();
            end
            load_params(1'b1);
            check("rnd_param_loaded", param_loaded, 1);
            for (int r = 0; r < 3; r++) begin
                for (int i = 0; i < N_IN; i++) x[i] = rnd_byte();
                send_inputs((s == 0) ? (rnd_byte() % 8) : rnd_byte());
                wait_done(400);
            end
        end
        rnd_ready = 1'b0;
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
